// File: rtl/cpu_clock_scheduler_pkg.sv
// Shared definitions for the CPU clock scheduler: FSM state encoding and clock constants.
package cpu_clock_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam int unsigned CPU_SYS_CLK_HZ  = 25_000_000;
  localparam int unsigned DEFAULT_CPU_DIV = 200;

endpackage

// File: rtl/cpu_clock_scheduler_if.sv
// Control and status bundle between the CPU clock scheduler and its controller.
interface cpu_clock_scheduler_if #(
  parameter int unsigned DIV_WIDTH  = 8,
  parameter int unsigned WAIT_WIDTH = 4
);
  logic [DIV_WIDTH-1:0]  div_value;
  logic                  run_req;
  logic                  step_req;
  logic                  slow_access;
  logic [WAIT_WIDTH-1:0] slow_wait;
  logic                  cpu_clk_enable;
  logic                  halted;
  logic                  wait_active;
  logic [31:0]           cycle_count;

  modport master (
    output div_value, run_req, step_req, slow_access, slow_wait,
    input  cpu_clk_enable, halted, wait_active, cycle_count
  );

  modport slave (
    input  div_value, run_req, step_req, slow_access, slow_wait,
    output cpu_clk_enable, halted, wait_active, cycle_count
  );
endinterface

// File: rtl/cpu_clock_scheduler_phase.sv
// Free-running CPU period counter; the divider is reloaded only at terminal count.
module cpu_phase_counter #(
  parameter int unsigned DIV_WIDTH   = 8,
  parameter int unsigned DEFAULT_DIV = 200
) (
  input  logic                 clk_25mhz,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] div_value,
  output logic                 tc
);
  logic [DIV_WIDTH-1:0] phase;
  logic [DIV_WIDTH-1:0] div_q;

  assign tc = (phase == div_q - DIV_WIDTH'(1));

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      div_q <= DIV_WIDTH'(DEFAULT_DIV);
    end else if (tc) begin
      phase <= '0;
      // 0 and 1 both select one clk per CPU cycle
      div_q <= (div_value == '0) ? DIV_WIDTH'(1) : div_value;
    end else begin
      phase <= phase + DIV_WIDTH'(1);
    end
  end
endmodule

// File: rtl/cpu_clock_scheduler.sv
// CPU clock-enable generator with run/halt/single-step control and per-access wait-state stretching.
module cpu_clock_scheduler
  import cpu_clock_scheduler_pkg::*;
#(
  parameter int unsigned DIV_WIDTH   = 8,
  parameter int unsigned DEFAULT_DIV = DEFAULT_CPU_DIV,
  parameter int unsigned WAIT_WIDTH  = 4,
  parameter bit          START_RUN   = 1'b1
) (
  input  logic                  clk_25mhz,
  input  logic                  rst_n,
  cpu_clock_scheduler_if.slave  sched
);
  localparam state_t RESET_STATE = START_RUN ? ST_RUN : ST_HALT;

  state_t                state_q, state_d;
  state_t                ret_q, ret_d;
  logic [WAIT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic                  step_req_q;
  logic                  step_pending;
  logic                  consume;
  logic                  grant;
  logic                  slow_hit;
  logic                  tc;

  cpu_phase_counter #(
    .DIV_WIDTH   (DIV_WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_phase (
    .clk_25mhz (clk_25mhz),
    .rst_n     (rst_n),
    .div_value (sched.div_value),
    .tc        (tc)
  );

  assign slow_hit = sched.slow_access && (sched.slow_wait != '0);

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    wait_cnt_d = wait_cnt_q;
    grant      = 1'b0;
    consume    = 1'b0;
    if (tc) begin
      case (state_q)
        ST_RUN: begin
          if (!sched.run_req) begin
            state_d = ST_HALT;
          end else if (slow_hit) begin
            state_d    = ST_WAIT;
            wait_cnt_d = sched.slow_wait;
            ret_d      = ST_RUN;
          end else begin
            grant = 1'b1;
          end
        end
        ST_HALT: begin
          if (sched.run_req) begin
            state_d = ST_RUN;
          end else if (step_pending) begin
            consume = 1'b1;
            if (slow_hit) begin
              state_d    = ST_WAIT;
              wait_cnt_d = sched.slow_wait;
              ret_d      = ST_HALT;
            end else begin
              grant = 1'b1;
            end
          end
        end
        ST_WAIT: begin
          // An access in progress always completes; a halt request only redirects the return state
          if (wait_cnt_q == WAIT_WIDTH'(1)) begin
            grant      = 1'b1;
            wait_cnt_d = '0;
            state_d    = (ret_q == ST_RUN && !sched.run_req) ? ST_HALT : ret_q;
          end else begin
            wait_cnt_d = wait_cnt_q - WAIT_WIDTH'(1);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      ret_q      <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // A fresh step edge wins over consumption of an older one; RUN discards any request
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      step_req_q   <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      step_req_q <= sched.step_req;
      if (state_q == ST_RUN) begin
        step_pending <= 1'b0;
      end else if (sched.step_req && !step_req_q) begin
        step_pending <= 1'b1;
      end else if (consume) begin
        step_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      sched.cpu_clk_enable <= 1'b0;
      sched.halted         <= !START_RUN;
      sched.wait_active    <= 1'b0;
      sched.cycle_count    <= '0;
    end else begin
      sched.cpu_clk_enable <= grant;
      sched.halted         <= (state_d == ST_HALT);
      sched.wait_active    <= (state_d == ST_WAIT);
      if (grant) begin
        sched.cycle_count <= sched.cycle_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_cpu_clock_scheduler.sv
// Directed bench for cpu_clock_scheduler: period timing, wait states, halt/step, divider reload, reset.
module tb_cpu_clock_scheduler;
  logic clk_25mhz;
  logic rst_n;

  int unsigned n_cmp;
  int unsigned n_err;

  cpu_clock_scheduler_if #(.DIV_WIDTH(8), .WAIT_WIDTH(4)) sched ();

  cpu_clock_scheduler #(
    .DIV_WIDTH   (8),
    .DEFAULT_DIV (200),
    .WAIT_WIDTH  (4),
    .START_RUN   (1'b1)
  ) dut (
    .clk_25mhz (clk_25mhz),
    .rst_n     (rst_n),
    .sched     (sched)
  );

  initial clk_25mhz = 1'b0;
  always #20 clk_25mhz = ~clk_25mhz;

  initial begin
    #(40 * 200000);
    $display("FAIL watchdog: run still active after 200000 clks (required: finished)");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // which: 0 = cpu_clk_enable, 1 = wait_active, 2 = halted; n = negedges until seen, -1 on timeout
  task automatic wait_signal(input int which, input int max_cycles, output int n);
    logic hit;
    n = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      @(negedge clk_25mhz);
      case (which)
        0:       hit = sched.cpu_clk_enable;
        1:       hit = sched.wait_active;
        default: hit = sched.halted;
      endcase
      if (hit === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic count_enables(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_25mhz);
      if (sched.cpu_clk_enable === 1'b1) pulses++;
    end
  endtask

  task automatic pulse_step();
    sched.step_req = 1'b1;
    @(negedge clk_25mhz);
    sched.step_req = 1'b0;
  endtask

  initial begin
    int n;
    int n2;
    int p;
    int unsigned exp_cnt;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    sched.div_value   = 8'd200;
    sched.run_req     = 1'b1;
    sched.step_req    = 1'b0;
    sched.slow_access = 1'b0;
    sched.slow_wait   = 4'd0;

    repeat (3) @(negedge clk_25mhz);
    check_val("rst_enable", {31'd0, sched.cpu_clk_enable}, 32'd0);
    check_val("rst_wait_active", {31'd0, sched.wait_active}, 32'd0);
    check_val("rst_halted", {31'd0, sched.halted}, 32'd0);
    check_val("rst_cycle_count", sched.cycle_count, 32'd0);

    // Free run at div 200: enable is sampled on the 200th negedge after release (clk cycle 201)
    rst_n = 1'b1;
    wait_signal(0, 400, n);
    check_val("t1_first_enable", n, 32'd200);
    for (int i = 0; i < 4; i++) begin
      wait_signal(0, 400, n);
      check_val("t1_gap", n, 32'd200);
    end
    check_val("t1_count", sched.cycle_count, 32'd5);
    exp_cnt = 5;

    // Slow access with 3 wait states: (3+1)*200 clks between enables
    sched.slow_access = 1'b1;
    sched.slow_wait   = 4'd3;
    wait_signal(1, 400, n);
    check_val("t2_wait_entry", n, 32'd200);
    sched.slow_access = 1'b0;
    wait_signal(0, 1000, n2);
    check_val("t2_slow_gap", n + n2, 32'd800);
    check_val("t2_wait_cleared", {31'd0, sched.wait_active}, 32'd0);
    exp_cnt++;
    wait_signal(0, 400, n);
    check_val("t2_gap_after", n, 32'd200);
    exp_cnt++;
    check_val("t2_count", sched.cycle_count, exp_cnt);

    // Halt, then a single step
    sched.run_req = 1'b0;
    wait_signal(2, 400, n);
    check_val("t3_halt_at_tc", n, 32'd200);
    count_enables(10000, p);
    check_val("t3_no_enables", p, 32'd0);
    check_val("t3_count_frozen", sched.cycle_count, exp_cnt);
    pulse_step();
    wait_signal(0, 400, n);
    check_val("t3_step_within_period", {31'd0, (n >= 1 && n <= 200)}, 32'd1);
    exp_cnt++;
    check_val("t3_step_count", sched.cycle_count, exp_cnt);
    check_val("t3_still_halted", {31'd0, sched.halted}, 32'd1);
    count_enables(1000, p);
    check_val("t3_single_step_only", p, 32'd0);

    // Resume, then drop run_req while a 2-wait access is in progress
    sched.run_req = 1'b1;
    wait_signal(0, 600, n);
    check_val("t5_resume_delay", {31'd0, (n > 200 && n <= 400)}, 32'd1);
    exp_cnt++;
    sched.slow_access = 1'b1;
    sched.slow_wait   = 4'd2;
    wait_signal(1, 400, n);
    check_val("t5_wait_entry", n, 32'd200);
    sched.run_req     = 1'b0;
    sched.slow_access = 1'b0;
    wait_signal(0, 800, n);
    check_val("t5_access_completes", n, 32'd400);
    check_val("t5_halted_after", {31'd0, sched.halted}, 32'd1);
    check_val("t5_wait_exit", {31'd0, sched.wait_active}, 32'd0);
    exp_cnt++;
    check_val("t5_count", sched.cycle_count, exp_cnt);
    count_enables(1000, p);
    check_val("t5_no_enables_halted", p, 32'd0);

    // A step edge during RUN must not produce an extra enable once halted
    sched.run_req = 1'b1;
    wait_signal(0, 600, n);
    exp_cnt++;
    pulse_step();
    wait_signal(0, 400, n);
    check_val("t5_run_gap_with_step", n, 32'd199);
    exp_cnt++;
    sched.run_req = 1'b0;
    wait_signal(2, 400, n);
    check_val("t5_halt_after_step", n, 32'd200);
    count_enables(1000, p);
    check_val("t5_step_dropped", p, 32'd0);
    check_val("t5_count_after_drop", sched.cycle_count, exp_cnt);

    // Divider change mid-period takes effect from the next period
    sched.run_req = 1'b1;
    wait_signal(0, 600, n);
    exp_cnt++;
    repeat (50) @(negedge clk_25mhz);
    sched.div_value = 8'd4;
    wait_signal(0, 400, n);
    check_val("t4_old_gap", n + 50, 32'd200);
    exp_cnt++;
    for (int i = 0; i < 2; i++) begin
      wait_signal(0, 400, n);
      check_val("t4_gap4", n, 32'd4);
      exp_cnt++;
    end
    sched.div_value = 8'd0;
    wait_signal(0, 400, n);
    check_val("t4_gap4_in_flight", n, 32'd4);
    exp_cnt++;
    for (int i = 0; i < 3; i++) begin
      wait_signal(0, 400, n);
      check_val("t4_div0_gap", n, 32'd1);
      exp_cnt++;
    end
    sched.div_value = 8'd1;
    for (int i = 0; i < 3; i++) begin
      wait_signal(0, 400, n);
      check_val("t4_div1_gap", n, 32'd1);
      exp_cnt++;
    end
    check_val("t4_count", sched.cycle_count, exp_cnt);

    // Asynchronous reset in the middle of a wait period
    sched.div_value   = 8'd200;
    sched.slow_access = 1'b1;
    sched.slow_wait   = 4'd3;
    wait_signal(1, 400, n);
    check_val("t6_wait_entry", n, 32'd1);
    repeat (100) @(negedge clk_25mhz);
    #5;
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_enable", {31'd0, sched.cpu_clk_enable}, 32'd0);
    check_val("t6_rst_wait_active", {31'd0, sched.wait_active}, 32'd0);
    check_val("t6_rst_count", sched.cycle_count, 32'd0);
    check_val("t6_rst_halted", {31'd0, sched.halted}, 32'd0);
    sched.slow_access = 1'b0;
    @(negedge clk_25mhz);
    rst_n = 1'b1;
    wait_signal(0, 400, n);
    check_val("t6_first_enable", n, 32'd200);
    wait_signal(0, 400, n);
    check_val("t6_gap", n, 32'd200);
    check_val("t6_count", sched.cycle_count, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
